// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, converter FSM states, the
// add-3 threshold and a helper that builds an all-nines BCD word.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_e;

  // A digit at or above this value gets +3 before the shift.
  localparam int unsigned BCD_ADJ_THRESH = 5;

  // Widest word bcd_max can build; callers slice the low digits they need.
  localparam int unsigned BCD_MAX_DIGITS = 32;

  // Returns n packed BCD nines in the low nibbles, zeros above.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] bcd_max(input int unsigned n);
    logic [4*BCD_MAX_DIGITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < n) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: valid/ready input of a binary operand
// and valid/ready output of the packed BCD result.
// The overflow signal exists only when BIN2BCD_OVF_EN is defined.
interface bin2bcd_seq_if #(
  parameter int N_DIGIT = 4,
  parameter int W_BIN   = 14
);

  logic                   in_valid;
  logic                   in_ready;
  logic [W_BIN-1:0]       bin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*N_DIGIT-1:0]   bcd;
`ifdef BIN2BCD_OVF_EN
  logic                   overflow;
`endif

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd
`ifdef BIN2BCD_OVF_EN
    , input overflow
`endif
  );

  // The converter itself.
  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd
`ifdef BIN2BCD_OVF_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/bcd_dabble_digit.sv
// One double-dabble cell: a BCD digit of 5..9 becomes 8..12, smaller
// digits pass through, so the result always fits 4 bits before the shift.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  // Conditional add-3 adjust.
  always_comb begin
    // NOTE: assigning a default first means every path drives q, so no latch is inferred.
    q = d;
    if (d >= bcd_digit_t'(BCD_ADJ_THRESH)) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional feature macro: BIN2BCD_OVF_EN adds a sticky overflow flag and
// saturates the result to all nines; without it the result wraps modulo
// 10^N_DIGIT.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGIT = 4,
  parameter int W_BIN   = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * N_DIGIT;
  localparam int SR_W  = BCD_W + W_BIN;
  localparam int CNT_W = $clog2(W_BIN + 1);

  b2b_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_sr;      // BCD half of the working register
  logic [W_BIN-1:0] bin_sr;      // binary half of the working register
  logic [BCD_W-1:0] bcd_adj;     // BCD half after the per-digit adjust
  logic [SR_W-1:0]  sr_shifted;  // adjusted register shifted left by one
  logic [BCD_W-1:0] bcd_q;       // held result presented on bus.bcd
  logic             accept;
  logic             last_step;

  for (genvar g = 0; g < N_DIGIT; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .d (bcd_sr[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  assign sr_shifted = {bcd_adj, bin_sr} << 1;
  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_step  = (state == SHIFT) && (cnt == CNT_W'(1));
  assign bus.bcd    = bcd_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Working register and bit counter: load on accept, shift during SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      bcd_sr <= '0;
      bin_sr <= '0;
    end else if (accept) begin
      cnt    <= CNT_W'(W_BIN);
      bcd_sr <= '0;
      bin_sr <= bus.bin;
    end else if (state == SHIFT) begin
      cnt              <= cnt - CNT_W'(1);
      {bcd_sr, bin_sr} <= sr_shifted;
    end
  end

`ifdef BIN2BCD_OVF_EN
  localparam logic [4*BCD_MAX_DIGITS-1:0] SAT_ALL = bcd_max(N_DIGIT);

  logic ovf_sticky;
  logic ovf_final;
  logic ovf_q;

  // A 1 leaving the top digit means the value needs more than N_DIGIT digits.
  assign ovf_final    = ovf_sticky | bcd_adj[BCD_W-1];
  assign bus.overflow = ovf_q;

  // Sticky overflow across the conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ovf_sticky <= 1'b0;
    else if (accept)         ovf_sticky <= 1'b0;
    else if (state == SHIFT) ovf_sticky <= ovf_final;
  end

  // Result capture on the final shift; saturate when the value did not fit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last_step) begin
      bcd_q <= ovf_final ? SAT_ALL[BCD_W-1:0] : sr_shifted[SR_W-1 -: BCD_W];
      ovf_q <= ovf_final;
    end
  end
`else
  // Result capture on the final shift; high digits simply fall off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bcd_q <= '0;
    else if (last_step) bcd_q <= sr_shifted[SR_W-1 -: BCD_W];
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver pushes expected results
// computed with plain decimal arithmetic, a monitor pops and compares on
// each output handshake and checks the accept-to-valid latency.
// Builds with or without BIN2BCD_OVF_EN.
module tb_bin2bcd_seq;

  localparam int N_DIGIT = 4;
  localparam int W_BIN   = 14;

  typedef struct {
    logic [63:0] bcd;
    bit          ovf;
    int unsigned acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t        exp_q[$];
  bit          stop_rand = 1'b0;

  bin2bcd_seq_if #(.N_DIGIT(N_DIGIT), .W_BIN(W_BIN)) if0 ();
  bin2bcd_seq_if #(.N_DIGIT(2),       .W_BIN(7))     if1 ();

  bin2bcd_seq #(.N_DIGIT(N_DIGIT), .W_BIN(W_BIN)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  bin2bcd_seq #(.N_DIGIT(2), .W_BIN(7)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: decimal digits of v, wrapped or saturated at 10^nd.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd, output bit ovf);
    longint unsigned lim = 1;
    longint unsigned x;
    logic [63:0]     r = '0;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (v >= lim);
`ifdef BIN2BCD_OVF_EN
    if (ovf) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'd9;
      return r;
    end
`endif
    x = v % lim;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Issue one operand on the main instance; called at a falling edge.
  task automatic send(input int unsigned v);
    exp_t        e;
    bit          o;
    int unsigned t = 0;
    while (!if0.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!if0.in_ready) begin
      fail("in_ready_timeout");
      return;
    end
    e.bcd     = ref_bcd(v, N_DIGIT, o);
    e.ovf     = o;
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    if0.bin      = W_BIN'(v);
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    if0.bin      = W_BIN'($urandom);
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  // Directed conversion on the 2-digit, 7-bit instance.
  task automatic small_conv(input int unsigned v);
    logic [63:0] eb;
    bit          eo;
    int unsigned a;
    int unsigned t = 0;
    eb = ref_bcd(v, 2, eo);
    if1.bin      = 7'(v);
    if1.in_valid = 1'b1;
    a            = cyc + 1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    while (!if1.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!if1.out_valid) begin
      fail("small_timeout");
      return;
    end
    check("small_latency", 64'(cyc - a), 64'd7);
    check("small_bcd", 64'(if1.bcd), eb);
`ifdef BIN2BCD_OVF_EN
    check("small_overflow", 64'(if1.overflow), 64'(eo));
`endif
    @(negedge clk);
  endtask

  // Monitor: compare each completed result against the scoreboard.
  initial begin : monitor
    bit   prev_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_valid = 1'b0;
        continue;
      end
      if (if0.out_valid && !prev_valid) begin
        if (exp_q.size() == 0) fail("unexpected_out_valid");
        else check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(W_BIN));
      end
      if (if0.out_valid && if0.out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_handshake");
        end else begin
          e = exp_q.pop_front();
          check("bcd", 64'(if0.bcd), e.bcd);
`ifdef BIN2BCD_OVF_EN
          check("overflow", 64'(if0.overflow), 64'(e.ovf));
`endif
        end
      end
      prev_valid = if0.out_valid;
    end
  end

  initial begin : stimulus
    if0.in_valid  = 1'b0;
    if0.bin       = '0;
    if0.out_ready = 1'b1;
    if1.in_valid  = 1'b0;
    if1.bin       = '0;
    if1.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst_bcd", 64'(if0.bcd), 64'd0);
`ifdef BIN2BCD_OVF_EN
    check("rst_overflow", 64'(if0.overflow), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(if0.in_ready), 64'd1);
    @(negedge clk);

    // Back-to-back directed values, then the first out-of-range value.
    send(0);
    send(1234);
    send(9999);
    send(10000);
    drain();

    // Randomised operands with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 20; i++) send($urandom_range(0, 16383));
        send(16383);
        drain();
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(negedge clk);
          if0.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    if0.out_ready = 1'b1;
    @(negedge clk);

    // Backpressure: result must hold and new input must be ignored.
    if0.out_ready = 1'b0;
    send(42);
    begin
      int unsigned t = 0;
      while (!if0.out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        if0.in_valid = 1'b1;
        if0.bin      = W_BIN'(777);
      end
      #1;
      check("bp_out_valid", 64'(if0.out_valid), 64'd1);
      check("bp_bcd", 64'(if0.bcd), 64'h0042);
      check("bp_in_ready", 64'(if0.in_ready), 64'd0);
      @(negedge clk);
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_out_valid", 64'(if0.out_valid), 64'd0);
    check("bp_release_in_ready", 64'(if0.in_ready), 64'd1);
    check("bp_hold_bcd", 64'(if0.bcd), 64'h0042);
    repeat (20) @(negedge clk);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a conversion.
    send(5555);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(if0.out_valid), 64'd0);
    check("midrst_bcd", 64'(if0.bcd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8000);
    drain();

    // Small instance: in-range and out-of-range.
    small_conv(99);
    small_conv(127);
    small_conv(5);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
